// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
// MDU_MADD_EN enables the multiply-accumulate family (MADD/MADDU/MSUB/MSUBU).
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = $clog2(DIV_CYCLES_DEF + 1);

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Operations that occupy the unit; the accumulate family only exists when enabled.
    function automatic logic is_start_op(input md_op_e op);
        logic ok;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: (op, a, b, hi, lo) -> {hi_n, lo_n} and div_zero.
// MDU_MADD_EN adds accumulate/subtract on top of the HI/LO base.
module md_arith
    import md_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] res,
    output logic        div_zero
);

    logic [63:0] acc_s;
    logic [63:0] sprod_s;
    logic [63:0] uprod_s;
    logic [31:0] b_safe_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;

    // Products and quotients; signed division works on magnitudes so 0x80000000/-1 wraps cleanly.
    always_comb begin
        acc_s    = {hi, lo};
        sprod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        uprod_s  = {32'd0, a} * {32'd0, b};
        div_zero = is_div_op(op) && (b == 32'd0);
        b_safe_s = (b == 32'd0) ? 32'd1 : b;
        a_mag_s  = a[31] ? (32'd0 - a) : a;
        b_mag_s  = b_safe_s[31] ? (32'd0 - b_safe_s) : b_safe_s;
        q_mag_s  = a_mag_s / b_mag_s;
        r_mag_s  = a_mag_s % b_mag_s;
        sq_s     = (a[31] ^ b_safe_s[31]) ? (32'd0 - q_mag_s) : q_mag_s;
        sr_s     = a[31] ? (32'd0 - r_mag_s) : r_mag_s;
        uq_s     = a / b_safe_s;
        ur_s     = a % b_safe_s;
    end

    // Result select; unsupported encodings pass HI/LO through unchanged.
    always_comb begin
        res = acc_s;
        case (op)
            MD_MULT:  res = sprod_s;
            MD_MULTU: res = uprod_s;
            MD_DIV:   res = {sr_s, sq_s};
            MD_DIVU:  res = {ur_s, uq_s};
`ifdef MDU_MADD_EN
            MD_MADD:  res = acc_s + sprod_s;
            MD_MADDU: res = acc_s + uprod_s;
            MD_MSUB:  res = acc_s - sprod_s;
            MD_MSUBU: res = acc_s - uprod_s;
`endif
            default:  res = acc_s;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO with fixed-latency commit and a busy flag for stalls.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU encodings.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic        req,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    md_op_e      op_s;
    logic        accept_s;
    logic [63:0] arith_res_s;
    logic        div_zero_s;

    md_state_e   state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [31:0] hi_r, hi_nxt_s;
    logic [31:0] lo_r, lo_nxt_s;
    logic [63:0] pend_r, pend_nxt_s;
    logic        dz_r, dz_nxt_s;

    assign op_s = md_op_e'(md_op);

    md_arith u_arith (
        .op       (op_s),
        .a        (a),
        .b        (b),
        .hi       (hi_r),
        .lo       (lo_r),
        .res      (arith_res_s),
        .div_zero (div_zero_s)
    );

    // Start acceptance and the stall-facing busy flag, high already in the accept cycle.
    always_comb begin
        accept_s = start && !req && (cnt_r == CW'(0)) && is_start_op(op_s);
        busy     = accept_s || (cnt_r != CW'(0));
    end

    // Next-state: capture result at start, count down, commit on the last busy cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        hi_nxt_s    = hi_r;
        lo_nxt_s    = lo_r;
        pend_nxt_s  = pend_r;
        dz_nxt_s    = dz_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = is_div_op(op_s) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    pend_nxt_s  = arith_res_s;
                    dz_nxt_s    = div_zero_s;
                end else if (!req && (op_s == MD_MTHI)) begin
                    hi_nxt_s = a;
                end else if (!req && (op_s == MD_MTLO)) begin
                    lo_nxt_s = a;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // req is ignored here: the op is already architecturally committed downstream.
                if (cnt_r == CW'(1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CW'(0);
                    hi_nxt_s    = dz_r ? hi_r : pend_r[63:32];
                    lo_nxt_s    = dz_r ? lo_r : pend_r[31:0];
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CW'(0);
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CW'(0);
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            pend_r  <= 64'd0;
            dz_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            hi_r    <= hi_nxt_s;
            lo_r    <= lo_nxt_s;
            pend_r  <= pend_nxt_s;
            dz_r    <= dz_nxt_s;
        end
    end

    // Read mux for mfhi/mflo.
    always_comb begin
        case (op_s)
            MD_MFHI: md_out = hi_r;
            MD_MFLO: md_out = lo_r;
            default: md_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic reference of HI/LO.
// Honours MDU_MADD_EN the same way as the design.
module tb_md_unit;
    import md_pkg::*;

    localparam int NM = 5;
    localparam int ND = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] md_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .req    (req),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .md_out (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {hi,lo} result from the architectural rules, using 64-bit integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [63:0] r, output bit dz, output bit ok);
        longint sx, sy, q, rm;
        logic [63:0] acc;
        acc = {m_hi, m_lo};
        r = acc; dz = 1'b0; ok = 1'b1;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            4'd1: r = sx * sy;
            4'd2: r = 64'(x) * 64'(y);
            4'd3: begin
                if (y == 32'd0) dz = 1'b1;
                else begin q = sx / sy; rm = sx % sy; r = {rm[31:0], q[31:0]}; end
            end
            4'd4: begin
                if (y == 32'd0) dz = 1'b1;
                else r = {x % y, x / y};
            end
`ifdef MDU_MADD_EN
            4'd9:  r = acc + 64'(sx * sy);
            4'd10: r = acc + 64'(x) * 64'(y);
            4'd11: r = acc - 64'(sx * sy);
            4'd12: r = acc - 64'(x) * 64'(y);
`endif
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reads LO then HI through md_out, one cycle each, both while idle.
    task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        md_op = MD_MFLO;
        @(negedge clk);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_lo"}, {32'd0, md_out}, {32'd0, el});
        next_cycle();
        md_op = MD_MFHI;
        @(negedge clk);
        check_eq({tag, "_hi"}, {32'd0, md_out}, {32'd0, eh});
        next_cycle();
        md_op = MD_NONE;
    endtask

    // Issue one md op (called just after a posedge), check busy every cycle, then read back.
    task automatic run_md(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input bit rq, input bit inject);
        logic [63:0] r;
        bit dz, ok;
        int n;
        model(op, x, y, r, dz, ok);
        ok = ok && !rq;
        start = 1'b1; md_op = op; a = x; b = y; req = rq;
        @(negedge clk);
        check_eq("busy_t0", {63'd0, busy}, {63'd0, ok});
        next_cycle();
        start = 1'b0; md_op = MD_NONE; req = 1'b0; a = $urandom; b = $urandom;
        n = ok ? (((op == 4'd3) || (op == 4'd4)) ? ND : NM) : 0;
        for (int i = 1; i <= n; i++) begin
            if (inject && i == 2) begin
                start = 1'b1; md_op = 4'($urandom_range(1, 4));
                req = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check_eq("busy_run", {63'd0, busy}, 64'd1);
            next_cycle();
            start = 1'b0; md_op = MD_NONE; req = 1'b0;
        end
        if (ok && !dz) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        read_hilo("after_op", m_hi, m_lo);
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] x, input bit rq);
        md_op = op; a = x; req = rq;
        @(negedge clk);
        check_eq("busy_mt", {63'd0, busy}, 64'd0);
        next_cycle();
        if (!rq && op == 4'd5) m_hi = x;
        if (!rq && op == 4'd6) m_lo = x;
        md_op = MD_NONE; req = 1'b0;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x, y;
        start = 1'b0; md_op = MD_NONE; req = 1'b0; a = 32'd0; b = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        read_hilo("reset", 32'd0, 32'd0);

        run_md(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        read_hilo("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_md(MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        read_hilo("divu", 32'd1, 32'd3);
        run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        read_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        read_hilo("div_ovf", 32'd0, 32'h80000000);

        do_mt(MD_MTHI, 32'h11, 1'b0);
        do_mt(MD_MTLO, 32'h22, 1'b0);
        run_md(MD_DIV, 32'd5, 32'd0, 1'b0, 1'b0);
        read_hilo("div0", 32'h11, 32'h22);

        run_md(MD_MULT, 32'd9, 32'd9, 1'b1, 1'b0);
        do_mt(MD_MTLO, 32'hABCD, 1'b1);
        read_hilo("req_block", 32'h11, 32'h22);

        // Reset two cycles into a multiply: nothing may commit afterwards.
        start = 1'b1; md_op = MD_MULT; a = 32'd1000; b = 32'd1000;
        next_cycle();
        start = 1'b0; md_op = MD_NONE;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_busy", {63'd0, busy}, 64'd0);
            next_cycle();
        end
        read_hilo("rst_mid", 32'd0, 32'd0);

        do_mt(MD_MTLO, 32'hFFFFFFFF, 1'b0);
        run_md(MD_MADD, 32'd1, 32'd1, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
        read_hilo("madd", 32'd1, 32'd0);
`else
        read_hilo("madd_off", 32'd0, 32'hFFFFFFFF);
`endif

        for (int k = 0; k < 40; k++) begin
            op = 4'($urandom_range(0, 12));
            case ($urandom_range(0, 3))
                0: x = 32'h80000000;
                1: x = 32'hFFFFFFFF;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: y = 32'd0;
                1: y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            if (op == 4'd5 || op == 4'd6) do_mt(op, x, 1'($urandom_range(0, 1)));
            else run_md(op, x, y, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        read_hilo("final", m_hi, m_lo);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
